// File: rtl/alu_share_arbiter.sv
// Two-requester front end for a single MIPSALU: round-robin grant, operand latch,
// one-cycle execute and a registered, id-tagged response channel.

module MIPSALU (
   input  logic [3:0]  ALUctl,
   input  logic [31:0] A,
   input  logic [31:0] B,
   output logic [31:0] ALUOut,
   output logic        Zero
);
   always_comb begin
      ALUOut = 32'd0;
      case (ALUctl)
         4'b0000: ALUOut = A & B;
         4'b0001: ALUOut = A | B;
         4'b0010: ALUOut = A + B;
         4'b0110: ALUOut = A - B;
         4'b0111: ALUOut = ($signed(A) < $signed(B)) ? 32'd1 : 32'd0;
         4'b1100: ALUOut = ~(A | B);
         default: ALUOut = 32'd0;
      endcase
   end

   assign Zero = (ALUOut == 32'd0);
endmodule

module alu_share_arbiter #(
   parameter bit RR_INIT = 1'b0,
   parameter int CNT_W   = 16
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [3:0]       req0_ctl,
   input  logic [31:0]      req0_a,
   input  logic [31:0]      req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [3:0]       req1_ctl,
   input  logic [31:0]      req1_a,
   input  logic [31:0]      req1_b,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [31:0]      rsp_result,
   output logic             rsp_zero,
   output logic             rsp_err,
   output logic             busy,
   output logic [CNT_W-1:0] op_count,
   output logic [1:0]       dbg_state
);
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   state_t           r_state;
   state_t           w_next;
   logic             r_ptr;
   logic [3:0]       r_ctl;
   logic [31:0]      r_a;
   logic [31:0]      r_b;
   logic             r_id;
   logic [31:0]      r_result;
   logic             r_zero;
   logic             r_err;
   logic [CNT_W-1:0] r_count;

   logic             w_gnt_id;
   logic             w_accept;
   logic             w_rsp_hs;
   logic             w_legal;
   logic [31:0]      w_alu_out;
   logic             w_alu_zero;

   // Handshakes: a transfer happens in any cycle where valid and ready are both
   // high at the rising edge; valid must not wait on ready, ready may depend on valid.
   assign w_gnt_id = (req0_valid && req1_valid) ? r_ptr : req1_valid;
   assign w_rsp_hs = (r_state == S_RESP) && rsp_ready;
   assign w_legal  = (r_ctl inside {4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b0111, 4'b1100});

   MIPSALU u_alu (
      .ALUctl (r_ctl),
      .A      (r_a),
      .B      (r_b),
      .ALUOut (w_alu_out),
      .Zero   (w_alu_zero)
   );

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_accept   = 1'b0;
      req0_ready = 1'b0;
      req1_ready = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (req0_valid || req1_valid) begin
               w_accept   = 1'b1;
               req0_ready = ~w_gnt_id;
               req1_ready = w_gnt_id;
               w_next     = S_EXEC;
            end
         end
         S_EXEC:  w_next = S_RESP;
         S_RESP:  if (rsp_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_ptr    <= RR_INIT;
         r_ctl    <= 4'd0;
         r_a      <= 32'd0;
         r_b      <= 32'd0;
         r_id     <= 1'b0;
         r_result <= 32'd0;
         r_zero   <= 1'b0;
         r_err    <= 1'b0;
         r_count  <= '0;
      end else begin
         if (w_accept) begin
            r_id  <= w_gnt_id;
            r_ctl <= w_gnt_id ? req1_ctl : req0_ctl;
            r_a   <= w_gnt_id ? req1_a   : req0_a;
            r_b   <= w_gnt_id ? req1_b   : req0_b;
         end
         if (r_state == S_EXEC) begin
            // Illegal codes report a zero result flagged as an error.
            r_result <= w_legal ? w_alu_out  : 32'd0;
            r_zero   <= w_legal ? w_alu_zero : 1'b1;
            r_err    <= ~w_legal;
         end
         if (w_rsp_hs) begin
            if (r_count != '1) r_count <= r_count + CNT_ONE;
            r_ptr <= ~r_id;
         end
      end
   end

   assign rsp_valid  = (r_state == S_RESP);
   assign rsp_id     = r_id;
   assign rsp_result = r_result;
   assign rsp_zero   = r_zero;
   assign rsp_err    = r_err;
   assign busy       = (r_state != S_IDLE);
   assign op_count   = r_count;
   assign dbg_state  = r_state;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter; a second instance with a 2-bit counter
// shares all inputs so counter saturation is observed alongside the main DUT.

module tb_alu_share_arbiter;
   logic        clock;
   logic        reset;
   logic        req0_valid, req1_valid;
   logic [3:0]  req0_ctl, req1_ctl;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic        rsp_ready;

   logic        req0_ready, req1_ready, rsp_valid, rsp_id, rsp_zero, rsp_err, busy;
   logic [31:0] rsp_result;
   logic [15:0] op_count;
   logic [1:0]  dbg_state;

   logic        s_req0_ready, s_req1_ready, s_rsp_valid, s_rsp_id, s_rsp_zero, s_rsp_err, s_busy;
   logic [31:0] s_rsp_result;
   logic [1:0]  s_op_count;
   logic [1:0]  s_dbg_state;

   int checks = 0;
   int errors = 0;

   alu_share_arbiter #(.RR_INIT(1'b0), .CNT_W(16)) dut (
      .clock(clock), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctl(req0_ctl),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctl(req1_ctl),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
      .rsp_result(rsp_result), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
      .busy(busy), .op_count(op_count), .dbg_state(dbg_state)
   );

   alu_share_arbiter #(.RR_INIT(1'b0), .CNT_W(2)) dut_sat (
      .clock(clock), .reset(reset),
      .req0_valid(req0_valid), .req0_ready(s_req0_ready), .req0_ctl(req0_ctl),
      .req0_a(req0_a), .req0_b(req0_b),
      .req1_valid(req1_valid), .req1_ready(s_req1_ready), .req1_ctl(req1_ctl),
      .req1_a(req1_a), .req1_b(req1_b),
      .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_id(s_rsp_id),
      .rsp_result(s_rsp_result), .rsp_zero(s_rsp_zero), .rsp_err(s_rsp_err),
      .busy(s_busy), .op_count(s_op_count), .dbg_state(s_dbg_state)
   );

   // Clock and reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic apply_reset();
      reset      = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      rsp_ready  = 1'b0;
      repeat (2) @(posedge clock);
      #1 reset = 1'b1;
   endtask

   // Drivers
   task automatic run_op(input logic id, input logic [3:0] ctl, input logic [31:0] a,
                         input logic [31:0] b, output int lat, output logic [31:0] res,
                         output logic zero, output logic err, output logic rid);
      int w;
      w = 0;
      if (id) begin
         req1_valid = 1'b1; req1_ctl = ctl; req1_a = a; req1_b = b;
      end else begin
         req0_valid = 1'b1; req0_ctl = ctl; req0_a = a; req0_b = b;
      end
      #1;
      while (!(id ? req1_ready : req0_ready) && w < 20) begin
         @(posedge clock); #1; w++;
      end
      @(posedge clock); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      lat = 1 + w;
      while (!rsp_valid && lat < 20) begin
         @(posedge clock); #1; lat++;
      end
      res  = rsp_result;
      zero = rsp_zero;
      err  = rsp_err;
      rid  = rsp_id;
      rsp_ready = 1'b1;
      @(posedge clock); #1;
      rsp_ready = 1'b0;
   endtask

   task automatic collect_one(output logic ok, output logic rid, output logic [31:0] res);
      int w;
      w = 0;
      rsp_ready = 1'b1;
      while (!rsp_valid && w < 20) begin
         @(posedge clock); #1; w++;
      end
      ok  = rsp_valid;
      rid = rsp_id;
      res = rsp_result;
      @(posedge clock); #1;
      rsp_ready = 1'b0;
   endtask

   // Scenarios
   task automatic test_reset();
      reset = 1'b0;
      #3;
      checks++;
      if ({rsp_valid, rsp_id, rsp_zero, rsp_err, busy} !== 5'b0) begin
         errors++; $display("FAIL reset_flags got %b exp 00000", {rsp_valid, rsp_id, rsp_zero, rsp_err, busy});
      end
      checks++;
      if (rsp_result !== 32'd0 || op_count !== 16'd0 || dbg_state !== 2'd0) begin
         errors++; $display("FAIL reset_regs got result %h count %0d state %0d exp 0 0 0", rsp_result, op_count, dbg_state);
      end
      checks++;
      if ({req0_ready, req1_ready} !== 2'b00) begin
         errors++; $display("FAIL reset_ready got %b exp 00", {req0_ready, req1_ready});
      end
      apply_reset();
   endtask

   task automatic test_basic_ops();
      logic [3:0]  ctls [4];
      logic [31:0] exps [4];
      int lat;
      logic [31:0] res;
      logic z, e, rid;
      ctls = '{4'b0000, 4'b0001, 4'b0010, 4'b0110};
      exps = '{32'h000000F0, 32'h000000FE, 32'h000001EE, 32'h0000000E};
      apply_reset();
      for (int i = 0; i < 4; i++) begin
         run_op(1'b0, ctls[i], 32'h000000FE, 32'h000000F0, lat, res, z, e, rid);
         checks++;
         if (lat !== 2) begin
            errors++; $display("FAIL basic_latency op %0d got %0d exp 2", i, lat);
         end
         checks++;
         if (res !== exps[i] || rid !== 1'b0 || z !== 1'b0 || e !== 1'b0) begin
            errors++; $display("FAIL basic_result op %0d got %h id %b z %b e %b exp %h id 0 z 0 e 0", i, res, rid, z, e, exps[i]);
         end
      end
      checks++;
      if (op_count !== 16'd4) begin
         errors++; $display("FAIL basic_count got %0d exp 4", op_count);
      end
   endtask

   task automatic test_req1_sub_slt();
      int lat;
      logic [31:0] res;
      logic z, e, rid;
      apply_reset();
      run_op(1'b1, 4'b0110, 32'h12345678, 32'h12345678, lat, res, z, e, rid);
      checks++;
      if (res !== 32'd0 || z !== 1'b1 || rid !== 1'b1 || e !== 1'b0 || lat !== 2) begin
         errors++; $display("FAIL sub_equal got %h z %b id %b e %b lat %0d exp 0 z 1 id 1 e 0 lat 2", res, z, rid, e, lat);
      end
      run_op(1'b1, 4'b0111, 32'h000000FE, 32'h000000F0, lat, res, z, e, rid);
      checks++;
      if (res !== 32'd0 || z !== 1'b1) begin
         errors++; $display("FAIL slt_false got %h z %b exp 0 z 1", res, z);
      end
      run_op(1'b0, 4'b0111, 32'h000000F0, 32'h000000FE, lat, res, z, e, rid);
      checks++;
      if (res !== 32'd1 || z !== 1'b0 || rid !== 1'b0) begin
         errors++; $display("FAIL slt_true got %h z %b id %b exp 1 z 0 id 0", res, z, rid);
      end
      run_op(1'b1, 4'b1100, 32'h0F0F0000, 32'h000000FF, lat, res, z, e, rid);
      checks++;
      if (res !== 32'hF0F0FF00) begin
         errors++; $display("FAIL nor got %h exp f0f0ff00", res);
      end
   endtask

   task automatic test_round_robin();
      logic        ok, rid;
      logic [31:0] res;
      logic        exp_id;
      apply_reset();
      req0_ctl = 4'b0010; req0_a = 32'd5; req0_b = 32'd7;
      req1_ctl = 4'b1100; req1_a = 32'd0; req1_b = 32'hFFFF0000;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      for (int i = 0; i < 4; i++) begin
         exp_id = (i % 2 == 1);
         collect_one(ok, rid, res);
         checks++;
         if (ok !== 1'b1 || rid !== exp_id || res !== (exp_id ? 32'h0000FFFF : 32'd12)) begin
            errors++; $display("FAIL rr_grant %0d got ok %b id %b res %h exp ok 1 id %b res %h", i, ok, rid, res, exp_id, exp_id ? 32'h0000FFFF : 32'd12);
         end
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      checks++;
      if (op_count !== 16'd4) begin
         errors++; $display("FAIL rr_count got %0d exp 4", op_count);
      end
      checks++;
      if (s_op_count !== 2'd3) begin
         errors++; $display("FAIL rr_sat_count got %0d exp 3", s_op_count);
      end
   endtask

   task automatic test_resp_stall();
      apply_reset();
      req0_ctl = 4'b0000; req0_a = 32'h0000F0F0; req0_b = 32'h0000FF00;
      req0_valid = 1'b1;
      #1;
      @(posedge clock); #1;
      req0_valid = 1'b0;
      checks++;
      if (busy !== 1'b1 || rsp_valid !== 1'b0) begin
         errors++; $display("FAIL stall_exec got busy %b valid %b exp 1 0", busy, rsp_valid);
      end
      @(posedge clock); #1;
      req1_ctl = 4'b0001; req1_a = 32'd1; req1_b = 32'd2;
      req1_valid = 1'b1;
      #1;
      for (int i = 0; i < 5; i++) begin
         checks++;
         if (rsp_valid !== 1'b1 || rsp_result !== 32'h0000F000 || rsp_id !== 1'b0 ||
             rsp_zero !== 1'b0 || rsp_err !== 1'b0) begin
            errors++; $display("FAIL stall_hold cyc %0d got v %b res %h id %b z %b e %b exp 1 0000f000 0 0 0", i, rsp_valid, rsp_result, rsp_id, rsp_zero, rsp_err);
         end
         checks++;
         if ({req0_ready, req1_ready} !== 2'b00 || op_count !== 16'd0) begin
            errors++; $display("FAIL stall_ready cyc %0d got ready %b count %0d exp 00 0", i, {req0_ready, req1_ready}, op_count);
         end
         @(posedge clock); #1;
      end
      rsp_ready = 1'b1;
      #1;
      checks++;
      if (req1_ready !== 1'b0) begin
         errors++; $display("FAIL stall_no_accept_on_hs got %b exp 0", req1_ready);
      end
      @(posedge clock); #1;
      rsp_ready = 1'b0;
      checks++;
      if (rsp_valid !== 1'b0 || op_count !== 16'd1 || req1_ready !== 1'b1) begin
         errors++; $display("FAIL stall_after_hs got v %b count %0d r1 %b exp 0 1 1", rsp_valid, op_count, req1_ready);
      end
      @(posedge clock); #1;
      req1_valid = 1'b0;
      @(posedge clock); #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_result !== 32'd3) begin
         errors++; $display("FAIL stall_next_op got v %b id %b res %h exp 1 1 3", rsp_valid, rsp_id, rsp_result);
      end
      rsp_ready = 1'b1;
      @(posedge clock); #1;
      rsp_ready = 1'b0;
   endtask

   task automatic test_illegal_ctl();
      int lat;
      logic [31:0] res;
      logic z, e, rid;
      apply_reset();
      run_op(1'b0, 4'b0011, 32'd5, 32'd3, lat, res, z, e, rid);
      checks++;
      if (e !== 1'b1 || res !== 32'd0 || z !== 1'b1 || lat !== 2) begin
         errors++; $display("FAIL illegal got e %b res %h z %b lat %0d exp 1 0 1 2", e, res, z, lat);
      end
      run_op(1'b1, 4'b0001, 32'd0, 32'd0, lat, res, z, e, rid);
      checks++;
      if (e !== 1'b0 || res !== 32'd0 || z !== 1'b1 || rid !== 1'b1) begin
         errors++; $display("FAIL legal_after_illegal got e %b res %h z %b id %b exp 0 0 1 1", e, res, z, rid);
      end
   endtask

   task automatic test_reset_in_exec_and_sat();
      int lat;
      logic [31:0] res;
      logic z, e, rid, ok;
      logic seen;
      apply_reset();
      run_op(1'b0, 4'b0010, 32'd3, 32'd4, lat, res, z, e, rid);
      req0_ctl = 4'b0001; req0_a = 32'h10; req0_b = 32'h01;
      req1_ctl = 4'b0010; req1_a = 32'h20; req1_b = 32'h02;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b01) begin
         errors++; $display("FAIL ptr_after_id0 got %b exp 01", {req0_ready, req1_ready});
      end
      @(posedge clock); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      reset = 1'b0;
      #1;
      checks++;
      if (busy !== 1'b0 || rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_result !== 32'd0 ||
          op_count !== 16'd0 || dbg_state !== 2'd0) begin
         errors++; $display("FAIL exec_reset got busy %b v %b id %b res %h count %0d state %0d exp 0 0 0 0 0 0", busy, rsp_valid, rsp_id, rsp_result, op_count, dbg_state);
      end
      @(posedge clock); #1;
      reset = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (rsp_valid) seen = 1'b1;
         @(posedge clock); #1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++; $display("FAIL exec_reset_no_rsp got %b exp 0", seen);
      end
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      checks++;
      if ({req0_ready, req1_ready} !== 2'b10) begin
         errors++; $display("FAIL ptr_back_to_init got %b exp 10", {req0_ready, req1_ready});
      end
      collect_one(ok, rid, res);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      checks++;
      if (ok !== 1'b1 || rid !== 1'b0 || res !== 32'h11) begin
         errors++; $display("FAIL post_reset_op got ok %b id %b res %h exp 1 0 11", ok, rid, res);
      end
      for (int i = 0; i < 4; i++) run_op(1'b0, 4'b0010, i, 32'd1, lat, res, z, e, rid);
      checks++;
      if (op_count !== 16'd5) begin
         errors++; $display("FAIL count_five got %0d exp 5", op_count);
      end
      checks++;
      if (s_op_count !== 2'd3) begin
         errors++; $display("FAIL count_saturate got %0d exp 3", s_op_count);
      end
   endtask

   initial begin
      reset = 1'b0;
      req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
      req0_ctl = 4'd0; req1_ctl = 4'd0;
      req0_a = 32'd0; req0_b = 32'd0; req1_a = 32'd0; req1_b = 32'd0;
      test_reset();
      test_basic_ops();
      test_req1_sub_slt();
      test_round_robin();
      test_resp_stall();
      test_illegal_ctl();
      test_reset_in_exec_and_sat();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog time limit reached checks %0d errors %0d", checks, errors);
      $fatal(1);
   end
endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares one MIPSALU instance between two requesters (e.g. a PC/branch unit and an execute stage) through valid/ready handshakes.
- Arbitrates round-robin and latches the winner's operands and control code.
- Runs the ALU for one cycle and returns a registered result on a single response channel tagged with the requester id.
- Instantiates MIPSALU internally.

Parameters:
- RR_INIT, 0: requester that holds priority after reset (0 or 1).
- CNT_W, 16: width of the completed-operation counter.

Ports:
- clock  in  1  single system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has an operation.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_ctl  in  4  ALU control code from requester 0.
- req0_a, req0_b  in  32 each  operands from requester 0.
- req1_valid, req1_ready, req1_ctl, req1_a, req1_b: same as requester 0, for requester 1.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  consumer accepts response.
- rsp_id  out  1  requester that issued the operation.
- rsp_result  out  32  ALU result.
- rsp_zero  out  1  result equals 0.
- rsp_err  out  1  illegal control code.
- busy  out  1  high whenever state != IDLE.
- op_count  out  CNT_W  saturating count of completed response handshakes.

Behaviour:
- Reset: asynchronous, active-low; takes effect immediately, no clock needed.
  - state=IDLE; priority pointer=RR_INIT.
  - rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_err=0, busy=0, op_count=0.
  - Operand, control and id registers cleared.
- States: IDLE, EXEC, RESP.
- IDLE:
  - Grant logic is combinational. If exactly one reqN_valid, grant N. If both are valid, grant the requester named by the priority pointer.
  - reqN_ready=1 only for the granted requester, only in IDLE. The accept is the handshake in that cycle.
  - On accept, latch ctl/a/b and the id, then go to EXEC. With no valid request, stay in IDLE.
- EXEC (exactly one cycle):
  - ALU inputs come from the latched registers only; requester inputs are ignored.
  - Legal ctl codes: 0000 AND, 0001 OR, 0010 add, 0110 sub, 0111 slt, 1100 nor.
  - Legal code: rsp_result<=ALUOut, rsp_zero<=Zero, rsp_err<=0.
  - Illegal code: rsp_result<=0, rsp_zero<=1, rsp_err<=1.
  - Add/sub wrap modulo 2^32; no overflow flag.
  - Go to RESP.
- RESP:
  - rsp_valid=1. rsp_id/result/zero/err are held stable until rsp_ready=1.
  - On handshake: op_count+1 (saturates at all-ones); priority pointer <= ~rsp_id; go to IDLE.
- Latency: accept in cycle N gives rsp_valid in cycle N+2. Best-case throughput is one operation per 3 cycles.
- Both ready outputs are 0 in EXEC and RESP. Requesters keep valid and operands stable until accepted; a requester dropping valid before accept loses nothing and is not tracked.
- A new request cannot be accepted in the same cycle as the response handshake; it is accepted next cycle in IDLE.
- Reset asserted in EXEC or RESP discards the in-flight operation; no response is produced for it.
- A single requester that is continuously valid is served back-to-back. The pointer only matters when both are valid, and alternation then guarantees no starvation.

Test Plan:
1. Reset, req0 only, A=0x000000FE, B=0x000000F0:
   - ctl 0000 -> rsp_result=0x000000F0, rsp_id=0, rsp_zero=0.
   - ctl 0001 -> 0x000000FE.
   - ctl 0010 -> 0x000001EE.
   - ctl 0110 -> 0x0000000E.
   - Each rsp_valid exactly 2 cycles after accept.
2. req1 sub, A=B=0x12345678 -> rsp_result=0, rsp_zero=1, rsp_id=1. Also slt A=0xFE, B=0xF0 -> 0; slt A=0xF0, B=0xFE -> 1.
3. RR_INIT=0, both valid continuously with distinct ops -> grants alternate 0,1,0,1 (rsp_id sequence), op_count=4 after four handshakes.
4. rsp_ready held 0 for 5 cycles in RESP -> rsp_valid and all response fields stable, both readys 0, op_count unchanged; single handshake when rsp_ready=1.
5. ctl=0011 -> rsp_err=1, rsp_result=0, rsp_zero=1; the following legal op returns rsp_err=0.
6. reset pulsed low in EXEC -> outputs at reset values immediately, no response appears, pointer returns to RR_INIT. CNT_W=2 with 5 ops -> op_count saturates at 3.
